router_pkt_reader: RTL

- Read-side consumer for one router output port; the other end of the synchronizer's valid_out/read_enb/soft_reset handshake.
- Watches valid_out, drives read_enb into the port FIFO and captures the FIFO's registered data_out.
- Reassembles each packet (header, payload, parity), checks parity and presents framed bytes to the sink.
- One instance per output port (0..2) in the router top.

---
 rtl/router_pkt_reader.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: read-side consumer for one router output port.
// Pulls bytes from the port FIFO, reframes each packet and checks its parity.
module router_pkt_reader #(
  parameter int START_DELAY = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_out,
  input  logic             soft_reset,
  input  logic [7:0]       data_out,
  input  logic             sink_ready,
  output logic             read_enb,
  output logic [7:0]       pkt_data,
  output logic             pkt_valid,
  output logic             pkt_sop,
  output logic             pkt_eop,
  output logic             parity_err,
  output logic             abort,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [7:0]       err_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_DLY = 3'd1,
    ST_RD_HDR   = 3'd2,
    ST_RD_PAY   = 3'd3,
    ST_RD_PAR   = 3'd4
  } state_t;

  localparam logic [4:0]       DLY_INIT = 5'(START_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t     state_r, state_next_s;
  logic [4:0] dly_cnt_r;
  logic       issued_r;
  logic [5:0] len_r, issue_cnt_r, rcv_cnt_r;
  logic [7:0] par_r;
  logic       rd_q_r;
  logic       issue_ok_s, read_enb_s, abort_s;
  logic       hdr_cap_s, pay_cap_s, par_cap_s, par_bad_s, emit_s;

  logic [7:0]       pkt_data_r, err_count_r;
  logic             pkt_valid_r, pkt_sop_r, pkt_eop_r, parity_err_r, abort_r, busy_r;
  logic [CNT_W-1:0] pkt_count_r;

  // Read gating, capture strobes and next-state selection.
  always_comb begin
    state_next_s = state_r;
    issue_ok_s   = 1'b0;
    abort_s      = soft_reset && (state_r != ST_IDLE);
    hdr_cap_s    = rd_q_r && (state_r == ST_RD_HDR);
    pay_cap_s    = rd_q_r && (state_r == ST_RD_PAY);
    par_cap_s    = rd_q_r && (state_r == ST_RD_PAR);
    par_bad_s    = (data_out != par_r);
    emit_s       = rd_q_r && !abort_s;

    // Header and parity get a single read each; payload reads stop at L.
    case (state_r)
      ST_RD_HDR: issue_ok_s = !issued_r;
      ST_RD_PAY: issue_ok_s = (issue_cnt_r < len_r);
      ST_RD_PAR: issue_ok_s = !issued_r;
      default:   issue_ok_s = 1'b0;
    endcase
    read_enb_s = issue_ok_s && valid_out && sink_ready;

    if (abort_s) begin
      state_next_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (valid_out) begin
            state_next_s = (DLY_INIT == 5'd0) ? ST_RD_HDR : ST_WAIT_DLY;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_WAIT_DLY: begin
          if (dly_cnt_r <= 5'd1) begin
            state_next_s = ST_RD_HDR;
          end else begin
            state_next_s = ST_WAIT_DLY;
          end
        end
        ST_RD_HDR: begin
          if (hdr_cap_s) begin
            state_next_s = (data_out[7:2] == 6'd0) ? ST_RD_PAR : ST_RD_PAY;
          end else begin
            state_next_s = ST_RD_HDR;
          end
        end
        ST_RD_PAY: begin
          if (pay_cap_s && ((rcv_cnt_r + 6'd1) == len_r)) begin
            state_next_s = ST_RD_PAR;
          end else begin
            state_next_s = ST_RD_PAY;
          end
        end
        ST_RD_PAR: begin
          if (par_cap_s) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_RD_PAR;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= ST_IDLE;
    else         state_r <= state_next_s;
  end

  // Read tracking, payload counters and running parity.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q_r      <= 1'b0;
      dly_cnt_r   <= 5'd0;
      issued_r    <= 1'b0;
      issue_cnt_r <= 6'd0;
      rcv_cnt_r   <= 6'd0;
      len_r       <= 6'd0;
      par_r       <= 8'd0;
    end else begin
      // A read issued while aborting is discarded when its data lands.
      rd_q_r      <= read_enb_s && !abort_s;
      dly_cnt_r   <= (state_r == ST_WAIT_DLY) ? (dly_cnt_r - 5'd1) : DLY_INIT;
      issued_r    <= (state_next_s != state_r) ? 1'b0 : (issued_r || read_enb_s);
      issue_cnt_r <= (state_r != ST_RD_PAY) ? 6'd0 : (issue_cnt_r + {5'd0, read_enb_s});
      rcv_cnt_r   <= (state_r != ST_RD_PAY) ? 6'd0 : (rcv_cnt_r + {5'd0, pay_cap_s});
      if (hdr_cap_s) begin
        len_r <= data_out[7:2];
        par_r <= data_out;
      end else if (pay_cap_s) begin
        par_r <= parity_acc(par_r, data_out);
      end
    end
  end

  // Framed output bytes, status pulses and packet counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_data_r   <= 8'd0;
      pkt_valid_r  <= 1'b0;
      pkt_sop_r    <= 1'b0;
      pkt_eop_r    <= 1'b0;
      parity_err_r <= 1'b0;
      abort_r      <= 1'b0;
      busy_r       <= 1'b0;
      pkt_count_r  <= {CNT_W{1'b0}};
      err_count_r  <= 8'd0;
    end else begin
      pkt_valid_r  <= emit_s;
      pkt_sop_r    <= hdr_cap_s && !abort_s;
      pkt_eop_r    <= par_cap_s && !abort_s;
      parity_err_r <= par_cap_s && !abort_s && par_bad_s;
      abort_r      <= abort_s;
      busy_r       <= (state_next_s != ST_IDLE);
      if (emit_s) pkt_data_r <= data_out;
      if (par_cap_s && !abort_s) begin
        if (par_bad_s) begin
          if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
        end else begin
          pkt_count_r <= pkt_count_r + CNT_ONE;
        end
      end
    end
  end

  assign read_enb   = read_enb_s;
  assign pkt_data   = pkt_data_r;
  assign pkt_valid  = pkt_valid_r;
  assign pkt_sop    = pkt_sop_r;
  assign pkt_eop    = pkt_eop_r;
  assign parity_err = parity_err_r;
  assign abort      = abort_r;
  assign busy       = busy_r;
  assign pkt_count  = pkt_count_r;
  assign err_count  = err_count_r;

endmodule
